term_parser: RTL and testbench
==============================

Name: term_parser

Overview:
- Parametrised successor to the byte parser. Consumes ASCII bytes from the RX FIFO, maintains a cursor over a COLS x ROWS character grid, and mirrors every visible change into both the display buffer and the HD44780-style lcd_ctrl.
- Adds row wrap/clamp modes, carriage return, backspace, tab and a buffer-filling clear.
- Explicit DDRAM repositioning so the block works for 1-4 row panels.
- Sits between the UART RX FIFO and display_buffer/lcd_ctrl.

Parameters:
- COLS, 16, characters per row (1-40).
- ROWS, 2, rows (1-4).
- WRAP_MODE, 0, 0 = wrap from last row to row 0; 1 = clamp at last cell, further chars overwrite it.
- TAB_W, 4, tab stop spacing; power of two, at most COLS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- fifo_dout  in  8  FIFO read data, valid the cycle after fifo_rd.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd  out  1  one-cycle FIFO pop strobe.
- buf_we  out  1  display buffer write enable.
- buf_addr  out  $clog2(COLS*ROWS)  buffer address, row*COLS+col.
- buf_din  out  8  buffer write data.
- lcd_valid  out  1  LCD transaction valid.
- lcd_data  out  8  LCD byte.
- lcd_is_data  out  1  1 = character data (RS=1), 0 = command.
- lcd_ready  in  1  lcd_ctrl accepts the transaction.
- cursor_row  out  $clog2(ROWS) (min 1)  current row.
- cursor_col  out  $clog2(COLS) (min 1)  current column.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state IDLE, all outputs 0, cursor (0,0). Reset aborts any operation mid-transaction, including a held lcd_valid or a partial clear. Buffer contents are not cleared by reset.
- LCD handshake:
  - lcd_valid, lcd_data and lcd_is_data are held stable until a posedge with lcd_valid & lcd_ready. The transfer happens on that edge.
  - The next transaction may be presented the following cycle. lcd_valid never drops without a transfer, except on rst.
- FSM states: IDLE, FETCH, DECODE, CLR_FILL, LCD_TX, then return.
  - IDLE: if !fifo_empty, pulse fifo_rd for exactly one cycle and go to FETCH.
  - FETCH: latch fifo_dout, go to DECODE.
  - Fetch latency: 2 cycles from the fifo_rd pulse to DECODE.
  - At most one byte is popped per command; no new pop occurs until the command completes.
- Printable bytes 0x20-0x7E:
  - buf_we=1 for one cycle with addr(cursor) and the byte.
  - LCD data transaction with the byte.
  - Advance col. If col was COLS-1, go to col 0 of row+1; past the last row, wrap to row 0 (WRAP_MODE=0).
  - WRAP_MODE=1 at the last cell: cursor unchanged, no SETPOS.
  - Any row change appends a SETPOS command: 0x80 | (row_base[row] + col), with row_base = 0x00, 0x40, COLS, 0x40+COLS.
- 0x0A newline: col=0, row advances per the wrap rules, then SETPOS.
- 0x0D CR: col=0, then SETPOS.
- 0x08 backspace:
  - col=0: no effect; byte consumed, no LCD traffic.
  - Otherwise col-1; buffer write 0x20 at the new cursor; LCD sequence SETPOS, DATA 0x20, SETPOS.
- 0x09 tab: col = min((col & ~(TAB_W-1)) + TAB_W, COLS-1), then SETPOS. No buffer writes.
- 0x0C clear:
  - CLR_FILL writes 0x20 to addresses 0..COLS*ROWS-1, one per cycle.
  - Then LCD command 0x01; cursor (0,0).
  - No FIFO pops occur during the fill.
- All other bytes: consumed silently, no outputs.
- No buffer write and LCD transfer ever coincide with fifo_rd. buf_we is never asserted while waiting on lcd_ready.

Decomposition:
- term_pkg holds:
  - control code constants CC_BS=0x08, CC_TAB=0x09, CC_LF=0x0A, CC_FF=0x0C, CC_CR=0x0D;
  - LCD constants LCD_CLEAR=0x01, LCD_SETPOS=0x80;
  - the state enum;
  - the space character 0x20.
- Sub-module lcd_ddram_map is combinational: (row, col) -> 7-bit DDRAM address, parametrised by COLS.

Test Plan:
- 0x0C then "Hello", COLS=16 ROWS=2, lcd_ready=1 -> buffer 0-4 = "Hello", 5-31 = 0x20; LCD sequence cmd 01, data 48 65 6C 6C 6F; cursor (0,5).
- 17 x 'A' at cursor (0,0) -> buf addr 16 = 'A', cursor (1,1); LCD shows 16 data, cmd C0, data 41.
- WRAP_MODE=1, ROWS=1, COLS=8, 10 x 'x' -> addr 7 written three times; cursor stays (0,7); no SETPOS emitted.
- "ab", 0x08, 0x09 with TAB_W=4 -> addr 1 = 0x20; LCD 61 62 81 20 81 84; cursor (0,4).
- lcd_ready held 0 for 50 cycles mid-"Hi" -> lcd_valid/lcd_data stable, no fifo_rd or buf_we; completes after ready rises.
- rst pulsed during CLR_FILL at addr 10 -> next cycle all outputs 0, cursor (0,0); addrs 11-31 untouched.

Source files
------------

// File: rtl/term_pkg.sv
// Shared constants, state encoding and LCD op bundle for the terminal parser.
// Imported by term_parser.
package term_pkg;

  localparam logic [7:0] CC_BS  = 8'h08;
  localparam logic [7:0] CC_TAB = 8'h09;
  localparam logic [7:0] CC_LF  = 8'h0A;
  localparam logic [7:0] CC_FF  = 8'h0C;
  localparam logic [7:0] CC_CR  = 8'h0D;

  localparam logic [7:0] LCD_CLEAR  = 8'h01;
  localparam logic [7:0] LCD_SETPOS = 8'h80;

  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    CLR_FILL,
    LCD_TX
  } state_t;

  typedef struct packed {
    logic       is_data;
    logic [7:0] data;
  } lcd_op_t;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/lcd_ddram_map.sv
// HD44780 DDRAM address of a (row, col) cell.
// Rows 2/3 continue rows 0/1 past COLS.
module lcd_ddram_map #(
  parameter  int COLS = 16,
  parameter  int ROWS = 2,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  output logic [6:0]    addr
);

  logic [1:0] r2;
  logic [6:0] base;

  assign r2 = 2'(row);

  always_comb begin
    base = '0;
    unique case (r2)
      2'd0:    base = 7'h00;
      2'd1:    base = 7'h40;
      2'd2:    base = 7'(COLS);
      default: base = 7'(8'h40 + COLS);
    endcase
  end

  assign addr = base + 7'(col);

endmodule

// File: rtl/term_parser.sv
// Byte stream to character grid: cursor tracking, buffer writes and
// a short queue of LCD transactions per received byte.
module term_parser
  import term_pkg::*;
#(
  parameter  int COLS      = 16,
  parameter  int ROWS      = 2,
  parameter  int WRAP_MODE = 0,
  parameter  int TAB_W     = 4,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int AW = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    fifo_dout,
  input  logic          fifo_empty,
  output logic          fifo_rd,
  output logic          buf_we,
  output logic [AW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          lcd_valid,
  output logic [7:0]    lcd_data,
  output logic          lcd_is_data,
  input  logic          lcd_ready,
  output logic [RW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic          busy
);

  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(COLS * ROWS - 1);

  state_t        state;
  logic          fetch_wait;
  logic [7:0]    cur;
  lcd_op_t       q [4];
  logic [1:0]    q_cnt;
  logic [1:0]    q_idx;

  logic [AW-1:0] cur_addr;
  logic          at_col;
  logic          at_row;
  logic [RW-1:0] nrow;
  logic [CW-1:0] ncol;
  logic          wrap;
  logic [7:0]    tab_col;
  logic [6:0]    dd_addr;
  logic [7:0]    setpos;
  lcd_op_t       seq [4];
  logic [1:0]    seq_n;

  assign busy     = (state != IDLE);
  assign cur_addr = AW'(int'(cursor_row) * COLS + int'(cursor_col));
  assign at_col   = (cursor_col == LAST_COL);
  assign at_row   = (cursor_row == LAST_ROW);
  assign tab_col  = (8'(cursor_col) & ~8'(TAB_W - 1)) + 8'(TAB_W);

  // Cursor after the latched byte takes effect.
  always_comb begin
    nrow = cursor_row;
    ncol = cursor_col;
    wrap = 1'b0;
    unique case (1'b1)
      is_printable(cur): begin
        if (!at_col) begin
          ncol = cursor_col + 1'b1;
        end else if (!(at_row && WRAP_MODE != 0)) begin
          ncol = '0;
          nrow = at_row ? '0 : cursor_row + 1'b1;
          wrap = 1'b1;
        end
      end
      cur == CC_LF: begin
        ncol = '0;
        if (!at_row) nrow = cursor_row + 1'b1;
        else if (WRAP_MODE == 0) nrow = '0;
      end
      cur == CC_CR: ncol = '0;
      cur == CC_BS: begin
        if (cursor_col != '0) ncol = cursor_col - 1'b1;
      end
      cur == CC_TAB: begin
        ncol = (tab_col > 8'(COLS - 1)) ? LAST_COL
                                         : tab_col[CW-1:0];
      end
      default: ;
    endcase
  end

  lcd_ddram_map #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_map (
    .row (nrow),
    .col (ncol),
    .addr(dd_addr)
  );

  assign setpos = LCD_SETPOS | {1'b0, dd_addr};

  always_comb begin
    seq   = '{default: '0};
    seq_n = 2'd0;
    unique case (1'b1)
      is_printable(cur): begin
        seq[0] = '{1'b1, cur};
        seq[1] = '{1'b0, setpos};
        seq_n  = wrap ? 2'd2 : 2'd1;
      end
      cur == CC_LF, cur == CC_CR, cur == CC_TAB: begin
        seq[0] = '{1'b0, setpos};
        seq_n  = 2'd1;
      end
      cur == CC_BS && cursor_col != '0: begin
        seq[0] = '{1'b0, setpos};
        seq[1] = '{1'b1, CH_SPACE};
        seq[2] = '{1'b0, setpos};
        seq_n  = 2'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_wait  <= 1'b0;
      cur         <= '0;
      q_cnt       <= '0;
      q_idx       <= '0;
      fifo_rd     <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_din     <= '0;
      lcd_valid   <= 1'b0;
      lcd_data    <= '0;
      lcd_is_data <= 1'b0;
      cursor_row  <= '0;
      cursor_col  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_rd    <= 1'b1;
            fetch_wait <= 1'b1;
            state      <= FETCH;
          end
        end
        // First cycle pops, second sees the popped byte.
        FETCH: begin
          fifo_rd <= 1'b0;
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else begin
            cur   <= fifo_dout;
            state <= DECODE;
            if (is_printable(fifo_dout)) begin
              buf_we   <= 1'b1;
              buf_addr <= cur_addr;
              buf_din  <= fifo_dout;
            end else if (fifo_dout == CC_BS &&
                         cursor_col != '0) begin
              buf_we   <= 1'b1;
              buf_addr <= cur_addr - 1'b1;
              buf_din  <= CH_SPACE;
            end
          end
        end
        DECODE: begin
          buf_we     <= 1'b0;
          cursor_row <= nrow;
          cursor_col <= ncol;
          if (cur == CC_FF) begin
            buf_we   <= 1'b1;
            buf_addr <= '0;
            buf_din  <= CH_SPACE;
            state    <= CLR_FILL;
          end else if (seq_n == 2'd0) begin
            state <= IDLE;
          end else begin
            q     <= seq;
            q_cnt <= seq_n;
            q_idx <= 2'd1;
            lcd_valid <= 1'b1;
            {lcd_is_data, lcd_data} <= seq[0];
            state <= LCD_TX;
          end
        end
        CLR_FILL: begin
          if (buf_addr == LAST_ADDR) begin
            buf_we      <= 1'b0;
            cursor_row  <= '0;
            cursor_col  <= '0;
            q_cnt       <= 2'd1;
            q_idx       <= 2'd1;
            lcd_valid   <= 1'b1;
            lcd_is_data <= 1'b0;
            lcd_data    <= LCD_CLEAR;
            state       <= LCD_TX;
          end else begin
            buf_addr <= buf_addr + 1'b1;
          end
        end
        LCD_TX: begin
          if (lcd_ready) begin
            if (q_idx == q_cnt) begin
              lcd_valid   <= 1'b0;
              lcd_data    <= '0;
              lcd_is_data <= 1'b0;
              state       <= IDLE;
            end else begin
              {lcd_is_data, lcd_data} <= q[q_idx];
              q_idx <= q_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_term_parser.sv
// Directed bench: 16x2 wrapping instance and 8x1 clamping instance,
// each fed from a queue-backed FIFO with LCD and buffer monitors.
module tb_term_parser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 16x2, wrap
  logic [7:0] a_dout = '0;
  logic       a_empty = 1'b1;
  logic       a_rd, a_we, a_valid, a_is_data, a_busy;
  logic [4:0] a_addr;
  logic [7:0] a_din, a_data;
  logic       a_ready = 1'b1;
  logic [0:0] a_row;
  logic [3:0] a_col;

  // 8x1, clamp
  logic [7:0] b_dout = '0;
  logic       b_empty = 1'b1;
  logic       b_rd, b_we, b_valid, b_is_data, b_busy;
  logic [2:0] b_addr;
  logic [7:0] b_din, b_data;
  logic       b_ready = 1'b1;
  logic [0:0] b_row;
  logic [2:0] b_col;

  term_parser #(.COLS(16), .ROWS(2), .WRAP_MODE(0), .TAB_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .fifo_dout(a_dout), .fifo_empty(a_empty), .fifo_rd(a_rd),
    .buf_we(a_we), .buf_addr(a_addr), .buf_din(a_din),
    .lcd_valid(a_valid), .lcd_data(a_data),
    .lcd_is_data(a_is_data), .lcd_ready(a_ready),
    .cursor_row(a_row), .cursor_col(a_col), .busy(a_busy)
  );

  term_parser #(.COLS(8), .ROWS(1), .WRAP_MODE(1), .TAB_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .fifo_dout(b_dout), .fifo_empty(b_empty), .fifo_rd(b_rd),
    .buf_we(b_we), .buf_addr(b_addr), .buf_din(b_din),
    .lcd_valid(b_valid), .lcd_data(b_data),
    .lcd_is_data(b_is_data), .lcd_ready(b_ready),
    .cursor_row(b_row), .cursor_col(b_col), .busy(b_busy)
  );

  logic [7:0] a_q [$];
  logic [7:0] b_q [$];
  logic [8:0] a_log [$];
  logic [8:0] b_log [$];
  logic [7:0] a_mem [32];
  int a_hi_wr = 0;
  int a_bad = 0;
  int b_w7 = 0;
  int b_bad = 0;

  always @(posedge clk) begin
    logic [7:0] t;
    if (a_rd && a_q.size() > 0) begin
      t = a_q.pop_front();
      a_dout <= t;
    end
    if (b_rd && b_q.size() > 0) begin
      t = b_q.pop_front();
      b_dout <= t;
    end
    if (a_we) a_mem[a_addr] <= a_din;
    if (a_we && a_addr > 5'd10) a_hi_wr <= a_hi_wr + 1;
    if (b_we && b_addr == 3'd7) b_w7 <= b_w7 + 1;
    if (a_valid && a_ready) a_log.push_back({a_is_data, a_data});
    if (b_valid && b_ready) b_log.push_back({b_is_data, b_data});
    if (a_rd && (a_we || (a_valid && a_ready))) a_bad <= a_bad + 1;
    if (a_we && a_valid && !a_ready) a_bad <= a_bad + 1;
    if (b_rd && (b_we || (b_valid && b_ready))) b_bad <= b_bad + 1;
  end

  always @(negedge clk) begin
    a_empty <= (a_q.size() == 0);
    b_empty <= (b_q.size() == 0);
  end

  function automatic string fmt(input logic [8:0] l [$]);
    string s = "";
    foreach (l[i])
      s = {s, $sformatf(" %s%02h", l[i][8] ? "D" : "C", l[i][7:0])};
    return s;
  endfunction

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) a_q.push_back(s[i]);
  endtask

  task automatic wait_idle(input bit sel, output bit to);
    int stable = 0;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sel == 1'b0 ? (a_q.size() == 0 && !a_busy && !a_rd)
                      : (b_q.size() == 0 && !b_busy && !b_rd))
        stable++;
      else
        stable = 0;
      if (stable >= 4) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_rd, a_we, a_addr, a_din, a_valid, a_data, a_is_data,
         a_row, a_col, a_busy} !== '0) begin
      errors++;
      $display("FAIL reset_a: got we=%b valid=%b row=%0d col=%0d busy=%b, expected all 0",
               a_we, a_valid, a_row, a_col, a_busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({b_rd, b_we, b_addr, b_din, b_valid, b_data, b_is_data,
         b_row, b_col, b_busy} !== '0) begin
      errors++;
      $display("FAIL reset_b: got we=%b valid=%b col=%0d busy=%b, expected all 0",
               b_we, b_valid, b_col, b_busy);
    end
  endtask

  task automatic test_clear_hello;
    bit to;
    int bad = 0;
    a_log.delete();
    a_q.push_back(8'h0C);
    push_str("Hello");
    wait_idle(1'b0, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL hello_timeout: got busy, expected idle");
    end
    checks++;
    if ({a_mem[0], a_mem[1], a_mem[2], a_mem[3], a_mem[4]} !== "Hello") begin
      errors++;
      $display("FAIL hello_buf: got %h, expected %h",
               {a_mem[0], a_mem[1], a_mem[2], a_mem[3], a_mem[4]}, "Hello");
    end
    for (int i = 5; i < 32; i++) if (a_mem[i] !== 8'h20) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hello_fill: got %0d non-space cells, expected 0", bad);
    end
    checks++;
    if (fmt(a_log) != " C01 D48 D65 D6c D6c D6f") begin
      errors++;
      $display("FAIL hello_lcd: got%s, expected C01 D48 D65 D6c D6c D6f", fmt(a_log));
    end
    checks++;
    if ({a_row, a_col} !== {1'b0, 4'd5}) begin
      errors++;
      $display("FAIL hello_cursor: got (%0d,%0d), expected (0,5)", a_row, a_col);
    end
  endtask

  task automatic test_row_wrap;
    bit to;
    string exp = "";
    a_q.push_back(8'h0D);
    wait_idle(1'b0, to);
    a_log.delete();
    for (int i = 0; i < 17; i++) a_q.push_back(8'h41);
    wait_idle(1'b0, to);
    for (int i = 0; i < 16; i++) exp = {exp, " D41"};
    exp = {exp, " Cc0 D41"};
    checks++;
    if (to) begin
      errors++;
      $display("FAIL wrap_timeout: got busy, expected idle");
    end
    checks++;
    if (a_mem[16] !== 8'h41) begin
      errors++;
      $display("FAIL wrap_buf16: got %h, expected 41", a_mem[16]);
    end
    checks++;
    if ({a_row, a_col} !== {1'b1, 4'd1}) begin
      errors++;
      $display("FAIL wrap_cursor: got (%0d,%0d), expected (1,1)", a_row, a_col);
    end
    checks++;
    if (fmt(a_log) != exp) begin
      errors++;
      $display("FAIL wrap_lcd: got%s, expected%s", fmt(a_log), exp);
    end
  endtask

  task automatic test_bs_tab;
    bit to;
    a_q.push_back(8'h0C);
    wait_idle(1'b0, to);
    a_log.delete();
    push_str("ab");
    a_q.push_back(8'h08);
    a_q.push_back(8'h09);
    wait_idle(1'b0, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL bstab_timeout: got busy, expected idle");
    end
    checks++;
    if (a_mem[1] !== 8'h20) begin
      errors++;
      $display("FAIL bstab_buf1: got %h, expected 20", a_mem[1]);
    end
    checks++;
    if (fmt(a_log) != " D61 D62 C81 D20 C81 C84") begin
      errors++;
      $display("FAIL bstab_lcd: got%s, expected D61 D62 C81 D20 C81 C84", fmt(a_log));
    end
    checks++;
    if ({a_row, a_col} !== {1'b0, 4'd4}) begin
      errors++;
      $display("FAIL bstab_cursor: got (%0d,%0d), expected (0,4)", a_row, a_col);
    end
  endtask

  task automatic test_newline;
    bit to;
    a_log.delete();
    a_q.push_back(8'h0A);
    a_q.push_back(8'h0A);
    a_q.push_back(8'h07);
    a_q.push_back(8'h08);
    wait_idle(1'b0, to);
    checks++;
    if (fmt(a_log) != " Cc0 C80") begin
      errors++;
      $display("FAIL newline_lcd: got%s, expected Cc0 C80", fmt(a_log));
    end
    checks++;
    if ({a_row, a_col} !== {1'b0, 4'd0}) begin
      errors++;
      $display("FAIL newline_cursor: got (%0d,%0d), expected (0,0)", a_row, a_col);
    end
  endtask

  task automatic test_clamp;
    bit to;
    string exp = "";
    for (int i = 0; i < 10; i++) begin
      b_q.push_back(8'h78);
      exp = {exp, " D78"};
    end
    wait_idle(1'b1, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL clamp_timeout: got busy, expected idle");
    end
    checks++;
    if (b_w7 != 3) begin
      errors++;
      $display("FAIL clamp_writes7: got %0d, expected 3", b_w7);
    end
    checks++;
    if ({b_row, b_col} !== {1'b0, 3'd7}) begin
      errors++;
      $display("FAIL clamp_cursor: got (%0d,%0d), expected (0,7)", b_row, b_col);
    end
    checks++;
    if (fmt(b_log) != exp) begin
      errors++;
      $display("FAIL clamp_lcd: got%s, expected%s", fmt(b_log), exp);
    end
  endtask

  task automatic test_stall;
    bit to = 1'b1;
    logic [8:0] held;
    a_log.delete();
    a_ready = 1'b0;
    push_str("Hi");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_valid) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL stall_valid: got no lcd_valid, expected valid");
    end
    held = {1'b1, 8'h48};
    for (int i = 0; i < 50; i++) begin
      checks++;
      if ({a_valid, a_is_data, a_data, a_rd, a_we} !== {1'b1, held, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold: got v=%b d=%h rd=%b we=%b, expected v=1 d=48 rd=0 we=0",
                 a_valid, a_data, a_rd, a_we);
      end
      @(negedge clk);
    end
    a_ready = 1'b1;
    wait_idle(1'b0, to);
    checks++;
    if (fmt(a_log) != " D48 D69") begin
      errors++;
      $display("FAIL stall_lcd: got%s, expected D48 D69", fmt(a_log));
    end
    checks++;
    if ({a_mem[0], a_mem[1]} !== 16'h4869) begin
      errors++;
      $display("FAIL stall_buf: got %h%h, expected 4869", a_mem[0], a_mem[1]);
    end
  endtask

  task automatic test_reset_mid_clear;
    bit to = 1'b1;
    int hi0 = a_hi_wr;
    int log0 = a_log.size();
    a_q.push_back(8'h0C);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_we && a_addr == 5'd10) begin
        to = 1'b0;
        break;
      end
    end
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rstclr_reach: got no write to addr 10, expected one");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({a_rd, a_we, a_addr, a_din, a_valid, a_data, a_is_data,
         a_row, a_col, a_busy} !== '0) begin
      errors++;
      $display("FAIL rstclr_outputs: got we=%b addr=%0d row=%0d col=%0d busy=%b, expected all 0",
               a_we, a_addr, a_row, a_col, a_busy);
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (a_hi_wr != hi0) begin
      errors++;
      $display("FAIL rstclr_untouched: got %0d writes above 10, expected 0", a_hi_wr - hi0);
    end
    checks++;
    if (a_log.size() != log0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstclr_quiet: got %0d lcd ops busy=%b, expected 0 ops busy=0",
               a_log.size() - log0, a_busy);
    end
  endtask

  task automatic test_overlap;
    checks++;
    if (a_bad != 0 || b_bad != 0) begin
      errors++;
      $display("FAIL overlap: got %0d/%0d bad cycles, expected 0/0", a_bad, b_bad);
    end
  endtask

  initial begin
    test_reset();
    test_clear_hello();
    test_row_wrap();
    test_bs_tab();
    test_newline();
    test_clamp();
    test_stall();
    test_reset_mid_clear();
    test_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
